// File: rtl/lock_pkg.sv
// Shared state encoding and 5-bit display symbol codes for the combination lock.
package lock_pkg;

    typedef enum logic [2:0] {
        LOCKED  = 3'd0,
        L_ENTRY = 3'd1,
        OPEN    = 3'd2,
        O_ENTRY = 3'd3,
        CHANGE  = 3'd4,
        LOCKOUT = 3'd5
    } lock_state_e;

    localparam logic [4:0] SYM_C     = 5'd16;
    localparam logic [4:0] SYM_L     = 5'd17;
    localparam logic [4:0] SYM_S     = 5'd5;
    localparam logic [4:0] SYM_D     = 5'd13;
    localparam logic [4:0] SYM_O     = 5'd0;
    localparam logic [4:0] SYM_P     = 5'd18;
    localparam logic [4:0] SYM_E     = 5'd14;
    localparam logic [4:0] SYM_N     = 5'd19;
    localparam logic [4:0] SYM_DASH  = 5'd30;
    localparam logic [4:0] SYM_BLANK = 5'd31;

    // Symbol at position pos of the "CLSd" / "OPEN" banners, blank past the word.
    function automatic logic [4:0] banner_sym(input logic is_open, input int pos);
        logic [4:0] s;
        case (pos)
            0:       s = is_open ? SYM_O : SYM_C;
            1:       s = is_open ? SYM_P : SYM_L;
            2:       s = is_open ? SYM_E : SYM_S;
            3:       s = is_open ? SYM_N : SYM_D;
            default: s = SYM_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done flags the final counted cycle (and an idle counter).
module lock_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg <= {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination lock controller: code entry, relock, code change and timed lockout.
// Optional LOCK_BLINK_EN macro blinks the active entry position.
module combo_lock_ctrl
    import lock_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int BLINK_HALF     = 50000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    ent,
    input  logic                    change,
    input  logic [DIGIT_W-1:0]      sw,
    output logic                    unlocked,
    output logic                    alarm,
    output logic [3:0]              tries_left,
    output logic [2:0]              digit_idx,
    output logic [2:0]              state_o,
    output logic [NUM_DIGITS*5-1:0] disp
);

    localparam int BUF_W = NUM_DIGITS * DIGIT_W;

    function automatic logic [NUM_DIGITS*5-1:0] closed_banner();
        logic [NUM_DIGITS*5-1:0] v;
        v = '0;
        for (int p = 0; p < NUM_DIGITS; p++) begin
            v[(NUM_DIGITS-1-p)*5 +: 5] = banner_sym(1'b0, p);
        end
        return v;
    endfunction

    localparam logic [NUM_DIGITS*5-1:0] DISP_RESET = closed_banner();

    lock_state_e             state_reg, state_next;
    logic [BUF_W-1:0]        code_reg, code_next;
    logic [BUF_W-1:0]        entry_reg, entry_next;
    logic [BUF_W-1:0]        cand;
    logic [2:0]              idx_reg, idx_next;
    logic [3:0]              tries_reg, tries_next;
    logic                    unlocked_reg, alarm_reg;
    logic [NUM_DIGITS*5-1:0] disp_reg, disp_next;
    logic                    in_entry, last_digit, code_match;
    logic                    lock_load, lock_done, blink_off;

    assign in_entry   = (state_reg == L_ENTRY) || (state_reg == O_ENTRY) || (state_reg == CHANGE);
    assign last_digit = (idx_reg == 3'(NUM_DIGITS - 1));
    assign code_match = (cand == code_reg);

    // cand is the entry buffer with sw dropped into the active position.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
        logic [4:0] sym;

        assign cand[(NUM_DIGITS-1-gi)*DIGIT_W +: DIGIT_W] =
            (idx_reg == 3'(gi)) ? sw : entry_reg[(NUM_DIGITS-1-gi)*DIGIT_W +: DIGIT_W];

        always_comb begin
            sym = SYM_BLANK;
            if (state_reg == LOCKED) begin
                sym = banner_sym(1'b0, gi);
            end else if (state_reg == OPEN) begin
                sym = banner_sym(1'b1, gi);
            end else if (state_reg == LOCKOUT) begin
                sym = SYM_DASH;
            end else if (3'(gi) < idx_reg) begin
                sym = SYM_DASH;
            end else if (3'(gi) == idx_reg) begin
                sym = blink_off ? SYM_BLANK : {{(5-DIGIT_W){1'b0}}, sw};
            end
        end

        assign disp_next[(NUM_DIGITS-1-gi)*5 +: 5] = sym;
    end

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        entry_next = entry_reg;
        idx_next   = idx_reg;
        tries_next = tries_reg;
        if (state_reg == LOCKED) begin
            if (ent) begin
                state_next = L_ENTRY;
                entry_next = '0;
                idx_next   = '0;
            end
        end else if (in_entry) begin
            if (clr) begin
                entry_next = '0;
                idx_next   = '0;
            end else if (ent && !last_digit) begin
                entry_next = cand;
                idx_next   = idx_reg + 3'd1;
            end else if (ent) begin
                entry_next = '0;
                idx_next   = '0;
                if (state_reg == L_ENTRY) begin
                    if (code_match) begin
                        state_next = OPEN;
                        tries_next = 4'(MAX_TRIES);
                    end else if (tries_reg <= 4'd1) begin
                        state_next = LOCKOUT;
                        tries_next = 4'd0;
                    end else begin
                        state_next = LOCKED;
                        tries_next = tries_reg - 4'd1;
                    end
                end else if (state_reg == O_ENTRY) begin
                    state_next = code_match ? LOCKED : OPEN;
                end else begin
                    code_next  = cand;
                    state_next = OPEN;
                end
            end
        end else if (state_reg == OPEN) begin
            if (change || ent) begin
                state_next = change ? CHANGE : O_ENTRY;
                entry_next = '0;
                idx_next   = '0;
            end
        end else if (state_reg == LOCKOUT) begin
            if (lock_done) begin
                state_next = LOCKED;
                tries_next = 4'(MAX_TRIES);
            end
        end else begin
            state_next = LOCKED;
        end
    end

    assign lock_load = (state_next == LOCKOUT) && (state_reg != LOCKOUT);

    lock_timer #(.W(32)) u_lockout_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lock_load),
        .load_val (32'(LOCKOUT_CYCLES)),
        .done     (lock_done)
    );

`ifdef LOCK_BLINK_EN
    logic blink_load, blink_done, blink_phase_reg;

    // Any key activity restarts the blink so the new position is shown at once.
    assign blink_load = ent || clr || blink_done;
    assign blink_off  = blink_phase_reg;

    lock_timer #(.W(32)) u_blink_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (blink_load),
        .load_val (32'(BLINK_HALF)),
        .done     (blink_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_phase_reg <= 1'b0;
        end else if (ent || clr) begin
            blink_phase_reg <= 1'b0;
        end else if (blink_done) begin
            blink_phase_reg <= ~blink_phase_reg;
        end
    end
`else
    assign blink_off = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= LOCKED;
            code_reg     <= '0;
            entry_reg    <= '0;
            idx_reg      <= '0;
            tries_reg    <= 4'(MAX_TRIES);
            unlocked_reg <= 1'b0;
            alarm_reg    <= 1'b0;
            disp_reg     <= DISP_RESET;
        end else begin
            state_reg    <= state_next;
            code_reg     <= code_next;
            entry_reg    <= entry_next;
            idx_reg      <= idx_next;
            tries_reg    <= tries_next;
            unlocked_reg <= (state_next == OPEN) || (state_next == O_ENTRY) || (state_next == CHANGE);
            alarm_reg    <= (state_next == LOCKOUT);
            disp_reg     <= disp_next;
        end
    end

    assign unlocked   = unlocked_reg;
    assign alarm      = alarm_reg;
    assign tries_left = tries_reg;
    assign digit_idx  = idx_reg;
    assign state_o    = state_reg;
    assign disp       = disp_reg;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Randomized and directed bench for combo_lock_ctrl against a queue-based behavioural model.
module tb_combo_lock_ctrl;
    import lock_pkg::*;

    localparam int ND = 4;
    localparam int MT = 3;
    localparam int LC = 20;

    localparam int ST_LOCKED  = 0;
    localparam int ST_LENTRY  = 1;
    localparam int ST_OPEN    = 2;
    localparam int ST_OENTRY  = 3;
    localparam int ST_CHANGE  = 4;
    localparam int ST_LOCKOUT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        ent = 1'b0;
    logic        change = 1'b0;
    logic [3:0]  sw = 4'd0;
    logic        unlocked, alarm;
    logic [3:0]  tries_left;
    logic [2:0]  digit_idx, state_o;
    logic [19:0] disp;

    always #5 clk = ~clk;

    combo_lock_ctrl #(
        .NUM_DIGITS(ND), .DIGIT_W(4), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ent(ent), .change(change), .sw(sw),
        .unlocked(unlocked), .alarm(alarm), .tries_left(tries_left),
        .digit_idx(digit_idx), .state_o(state_o), .disp(disp)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0]  closed_word[4];
    logic [4:0]  open_word[4];
    int          m_state, m_tries, m_lock_left;
    int          q[$];
    int          m_code[ND];
    logic [19:0] m_disp;
    bit          chk_en = 1'b0;

    initial begin
        closed_word = '{SYM_C, SYM_L, SYM_S, SYM_D};
        open_word   = '{SYM_O, SYM_P, SYM_E, SYM_N};
    end

    function automatic logic [4:0] model_sym(input int p, input logic [3:0] s);
        if (m_state == ST_LOCKED)  return closed_word[p];
        if (m_state == ST_OPEN)    return open_word[p];
        if (m_state == ST_LOCKOUT) return SYM_DASH;
        if (p < q.size())          return SYM_DASH;
        if (p == q.size())         return {1'b0, s};
        return SYM_BLANK;
    endfunction

    task automatic model_reset();
        m_state = ST_LOCKED;
        m_tries = MT;
        m_lock_left = 0;
        q.delete();
        for (int i = 0; i < ND; i++) m_code[i] = 0;
        for (int p = 0; p < ND; p++) m_disp[(ND-1-p)*5 +: 5] = closed_word[p];
    endtask

    task automatic model_step();
        bit ok;
        for (int p = 0; p < ND; p++) m_disp[(ND-1-p)*5 +: 5] = model_sym(p, sw);
        case (m_state)
            ST_LOCKED: if (ent) begin m_state = ST_LENTRY; q.delete(); end
            ST_LENTRY, ST_OENTRY, ST_CHANGE: begin
                if (clr) q.delete();
                else if (ent) begin
                    q.push_back(int'(sw));
                    if (q.size() == ND) begin
                        ok = 1'b1;
                        for (int i = 0; i < ND; i++) if (q[i] != m_code[i]) ok = 1'b0;
                        if (m_state == ST_LENTRY) begin
                            if (ok) begin m_state = ST_OPEN; m_tries = MT; end
                            else begin
                                m_tries--;
                                if (m_tries == 0) begin m_state = ST_LOCKOUT; m_lock_left = LC; end
                                else m_state = ST_LOCKED;
                            end
                        end else if (m_state == ST_OENTRY) begin
                            m_state = ok ? ST_LOCKED : ST_OPEN;
                        end else begin
                            for (int i = 0; i < ND; i++) m_code[i] = q[i];
                            m_state = ST_OPEN;
                        end
                        q.delete();
                    end
                end
            end
            ST_OPEN: begin
                if (change) begin m_state = ST_CHANGE; q.delete(); end
                else if (ent) begin m_state = ST_OENTRY; q.delete(); end
            end
            default: begin
                if (m_lock_left == 1) begin m_state = ST_LOCKED; m_tries = MT; end
                else m_lock_left--;
            end
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state_o), 32'(m_state));
            check("unlocked", 32'(unlocked),
                  32'(m_state == ST_OPEN || m_state == ST_OENTRY || m_state == ST_CHANGE));
            check("alarm", 32'(alarm), 32'(m_state == ST_LOCKOUT));
            check("tries_left", 32'(tries_left), 32'(m_tries));
            check("digit_idx", 32'(digit_idx), 32'(q.size()));
            check("disp", 32'(disp), 32'(m_disp));
        end
    end

    // ---------------- stimulus ----------------
    task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] model_v,
                       input logic [31:0] want);
        check(name, dut_v, want);
        check({name, "_model"}, model_v, want);
    endtask

    task automatic step(input bit c, input bit e, input bit ch, input logic [3:0] s);
        clr = c; ent = e; change = ch; sw = s;
        @(negedge clk);
        clr = 1'b0; ent = 1'b0; change = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, sw);
    endtask

    // Four digits, MSD first; returns at the cycle right after the final ent.
    task automatic enter4(input logic [15:0] c);
        for (int i = 0; i < ND; i++) begin
            if (i != 0) idle();
            step(1'b0, 1'b1, 1'b0, c[15-4*i -: 4]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        lit("rst_state", 32'(state_o), 32'(m_state), ST_LOCKED);
        lit("rst_tries", 32'(tries_left), 32'(m_tries), 3);
        lit("rst_disp", 32'(disp), 32'(m_disp), 32'h844AD);
        rst_n = 1'b1;
        idle();

        // unlock with the reset code 0000
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle();
        enter4(16'h0000);
        lit("open_state", 32'(state_o), 32'(m_state), ST_OPEN);
        check("open_unlocked", 32'(unlocked), 32'd1);
        idle();
        lit("open_disp", 32'(disp), 32'(m_disp), 32'h049D3);

        // change code to 1234, relock with it, then one wrong attempt
        step(1'b0, 1'b0, 1'b1, 4'd0);
        idle();
        enter4(16'h1234);
        lit("chg_open", 32'(state_o), 32'(m_state), ST_OPEN);
        idle();
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle();
        enter4(16'h1234);
        lit("relock", 32'(state_o), 32'(m_state), ST_LOCKED);
        check("relock_unlocked", 32'(unlocked), 32'd0);
        idle();
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle();
        enter4(16'h0000);
        lit("tries_2", 32'(tries_left), 32'(m_tries), 2);

        // two more wrong attempts -> lockout
        for (int k = 0; k < 2; k++) begin
            idle();
            step(1'b0, 1'b1, 1'b0, 4'd0);
            idle();
            enter4(16'h0000);
        end
        lit("lockout", 32'(state_o), 32'(m_state), ST_LOCKOUT);
        check("lockout_alarm", 32'(alarm), 32'd1);
        for (int i = 1; i < LC; i++) begin
            step(i % 2 == 1, i % 3 == 0, i % 5 == 0, 4'(i));
            check("lockout_hold", 32'(alarm), 32'd1);
            if (i == 1) lit("lockout_disp", 32'(disp), 32'(m_disp), 32'hF7BDE);
        end
        idle();
        lit("lockout_exit", 32'(state_o), 32'(m_state), ST_LOCKED);
        lit("lockout_tries", 32'(tries_left), 32'(m_tries), 3);

        // partial entry, clr+ent together, then correct code
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle();
        step(1'b0, 1'b1, 1'b0, 4'd1);
        idle();
        step(1'b0, 1'b1, 1'b0, 4'd2);
        idle();
        lit("partial_idx", 32'(digit_idx), 32'(q.size()), 2);
        step(1'b1, 1'b1, 1'b0, 4'd5);
        lit("clr_idx", 32'(digit_idx), 32'(q.size()), 0);
        idle();
        enter4(16'h1234);
        lit("clr_unlock", 32'(state_o), 32'(m_state), ST_OPEN);

        // change and ent together in OPEN
        idle();
        step(1'b0, 1'b1, 1'b1, 4'd7);
        lit("chg_wins", 32'(state_o), 32'(m_state), ST_CHANGE);
        idle();
        lit("chg_disp", 32'(disp), 32'(m_disp), 32'h3FFFF);

        // reset mid-entry at digit_idx 2
        step(1'b0, 1'b1, 1'b0, 4'd1);
        idle();
        step(1'b0, 1'b1, 1'b0, 4'd2);
        idle();
        lit("mid_idx", 32'(digit_idx), 32'(q.size()), 2);
        #2 rst_n = 1'b0;
        #1;
        lit("mr_state", 32'(state_o), 32'(m_state), ST_LOCKED);
        lit("mr_idx", 32'(digit_idx), 32'(q.size()), 0);
        lit("mr_tries", 32'(tries_left), 32'(m_tries), 3);
        check("mr_unlocked", 32'(unlocked), 32'd0);
        check("mr_alarm", 32'(alarm), 32'd0);
        lit("mr_disp", 32'(disp), 32'(m_disp), 32'h844AD);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle();
        enter4(16'h0000);
        lit("mr_code_zero", 32'(state_o), 32'(m_state), ST_OPEN);

        // random traffic, digits biased to 0/1 so codes match often
        repeat (3000) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
